dac_playback_ctrl: RTL and testbench
====================================

DAC_PLAYBACK_CTRL -- requirements
Module: dac_playback_ctrl

Interface
REQ-001 SHALL have parameter NUM_CH, default 16: number of DAC channels.
REQ-002 SHALL have parameter DATA_W, default 256: AXIS word width per channel.
REQ-003 SHALL have parameter DEPTH, default 1024: words per channel buffer, power of two; ADDR_W = clog2(DEPTH).
REQ-004 SHALL have ports `pl_clk` (in, 1, sole clock) and `rst` (in, 1, asynchronous active-high reset).
REQ-005 SHALL have ports `s_axis_tdata` (in, DATA_W), `s_axis_tvalid` (in, 1), `s_axis_tlast` (in, 1) and `s_axis_tready` (out, 1): load stream.
REQ-006 SHALL have port `load_ch` (in, clog2(NUM_CH)): target channel of the load.
REQ-007 SHALL have ports `trigger` (in, 1, playback start), `loop_en` (in, 1, cyclic playback) and `abort` (in, 1, stop playback).
REQ-008 SHALL have ports `m_axis_tdata` (out, NUM_CH*DATA_W, channel i at [i*DATA_W +: DATA_W]), `m_axis_tvalid` (out, NUM_CH) and `m_axis_tready` (in, NUM_CH).
REQ-009 SHALL have status ports `busy` (out, 1), `done` (out, 1-cycle pulse), `overflow` (out, 1, sticky) and `underrun` (out, 1, sticky).

Function
REQ-010 SHALL implement FSM states IDLE, LOAD and PLAY.
REQ-011 IDLE/LOAD: `s_axis_tready`=1; PLAY: `s_axis_tready`=0.
REQ-012 On the first IDLE handshake: latch `load_ch` as the target, write the beat at address 0, and go to LOAD; `load_ch` changes are ignored until the load ends.
REQ-013 Each LOAD handshake SHALL write the next address; a tlast beat sets len[target] = beats written and returns to IDLE.
REQ-014 A tlast on the first IDLE beat SHALL give len=1 and remain in IDLE.
REQ-015 Beats beyond DEPTH SHALL be dropped and set `overflow`; len saturates at DEPTH.
REQ-016 A rising edge of `trigger` in IDLE with any len>0 SHALL enter PLAY the next cycle, clear `underrun` and reset rd_addr to 0.
REQ-017 A trigger in LOAD or PLAY, or with all len=0, SHALL be ignored.
REQ-018 Channel i is active while rd_addr < len[i]; `m_axis_tvalid[i]` = active and data valid; inactive channels drive tvalid 0 and tdata 0.
REQ-019 Channels SHALL advance in lockstep: rd_addr increments only when every channel with tvalid high sees tready high.
REQ-020 Any channel with tvalid high and tready low SHALL stall all channels (data held) and set `underrun`.
REQ-021 Read latency SHALL be fixed: trigger edge sampled at cycle T gives first valid beat at T+2.
REQ-022 After the final beat of max(len) is accepted with `loop_en`=0: return to IDLE and pulse `done` for 1 cycle.
REQ-023 At the end of playback with `loop_en`=1: wrap rd_addr to 0 with no bubble cycle and no `done` pulse.
REQ-024 `abort` in PLAY SHALL return to IDLE next cycle (abort wins over a simultaneous advance) with tvalid low; `done` is not pulsed.
REQ-025 `busy` SHALL be 1 in LOAD and PLAY.
REQ-026 len values SHALL persist across playbacks until reloaded.

Reset
REQ-027 `rst` SHALL asynchronously force IDLE and clear all len, rd_addr and wr_addr.
REQ-028 Reset values: `m_axis_tvalid`=0, `m_axis_tdata`=0, `s_axis_tready`=0 while `rst` is high, and `busy`/`done`/`overflow`/`underrun`=0.
REQ-029 Reset mid-LOAD or mid-PLAY SHALL discard the operation; buffer RAM contents are not cleared.

Configuration
REQ-030 Macro DAC_PLAYBACK_LOOP_EN defined: `loop_en` honoured per REQ-023.
REQ-031 Macro DAC_PLAYBACK_LOOP_EN undefined: `loop_en` is ignored, playback is always one-shot, and the port remains present.

Structure
REQ-032 Package rfsoc_config SHALL hold the FSM state typedef (enum IDLE/LOAD/PLAY) and default constants for NUM_CH, DATA_W and DEPTH.
REQ-033 Sub-module dac_channel_buffer SHALL be a per-channel simple dual-port RAM with synchronous read and read enable, generated NUM_CH times.

Verification
REQ-034 Load ch3 with 4 beats (tlast on beat 4) then trigger, tready all 1 -> ch3 outputs beats 0..3 starting at T+2, other channels tvalid 0, `done` pulse after beat 3.
REQ-035 Load ch0 len 2 and ch1 len 5, trigger -> ch0 valid for 2 beats, ch1 for 5, `done` after ch1 beat 4.
REQ-036 DEPTH=8: load 10 beats -> len=8, `overflow`=1, beats 8-9 dropped.
REQ-037 ch1 playing, drop m_axis_tready[1] for 3 cycles -> all channels hold data, `underrun`=1, playback resumes with no lost beat.
REQ-038 With DAC_PLAYBACK_LOOP_EN, loop_en=1, len 3 -> sequence 0,1,2,0,1,2 with no gap; abort -> IDLE next cycle, no `done`; without the macro -> single pass.
REQ-039 Assert `rst` mid-PLAY -> tvalid 0 immediately; a subsequent trigger with no reload -> ignored (all len=0).

Source files
------------

// File: rtl/rfsoc_config.sv
// rfsoc_config: shared types and default sizing for the DAC playback path.
package rfsoc_config;

  // Playback controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2
  } play_state_e;

  localparam int DEF_NUM_CH = 16;
  localparam int DEF_DATA_W = 256;
  localparam int DEF_DEPTH  = 1024;

  // Width of a channel index; a single-channel build still gets one bit.
  function automatic int ch_idx_w(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/dac_channel_buffer.sv
// dac_channel_buffer: one channel's sample store. Simple dual-port RAM with a
// synchronous read port; the read register holds its value while rd_en is
// low, which lets the playback path stall without a separate skid buffer.
module dac_channel_buffer #(
  parameter int DATA_W = 256,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int WORDS = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [WORDS];
  logic [DATA_W-1:0] rd_data_q;

  // Write port: store a loaded beat.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Read port: fetch on rd_en, otherwise hold the last word.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/dac_playback_ctrl.sv
// dac_playback_ctrl: multi-channel DAC playback controller. One AXI-Stream
// slave loads per-channel buffers; a trigger replays every loaded channel in
// lockstep on its own AXI-Stream master.
// Build option DAC_PLAYBACK_LOOP_EN: when defined, loop_en selects cyclic
// playback; when undefined, loop_en is ignored and playback is one-shot.
module dac_playback_ctrl
  import rfsoc_config::*;
#(
  parameter  int NUM_CH = DEF_NUM_CH,
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int DEPTH  = DEF_DEPTH,
  localparam int CH_W   = ch_idx_w(NUM_CH)
) (
  input  logic                     pl_clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        s_axis_tdata,
  input  logic                     s_axis_tvalid,
  input  logic                     s_axis_tlast,
  output logic                     s_axis_tready,
  input  logic [CH_W-1:0]          load_ch,
  input  logic                     trigger,
  input  logic                     loop_en,
  input  logic                     abort,
  output logic [NUM_CH*DATA_W-1:0] m_axis_tdata,
  output logic [NUM_CH-1:0]        m_axis_tvalid,
  input  logic [NUM_CH-1:0]        m_axis_tready,
  output logic                     busy,
  output logic                     done,
  output logic                     overflow,
  output logic                     underrun
);

  localparam int ADDR_W = $clog2(DEPTH);
  // Lengths and write counts need one extra bit to represent a full buffer.
  localparam int LEN_W  = ADDR_W + 1;

  play_state_e       state_q, state_d;
  logic [CH_W-1:0]   tgt_q, tgt_d;
  logic [LEN_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic [LEN_W-1:0]  len_q [NUM_CH];
  logic [LEN_W-1:0]  len_d [NUM_CH];
  logic              trig_q, trig_d;
  logic [LEN_W-1:0]  rd_addr_q, rd_addr_d;
  logic              ovld_q, ovld_d;
  logic [NUM_CH-1:0] tvalid_q, tvalid_d;
  logic              tready_q, tready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic              und_q, und_d;

  logic              load_hs_s;
  logic              trig_rise_s;
  logic              loop_s;
  logic              wr_en_s;
  logic [CH_W-1:0]   wr_ch_s;
  logic [ADDR_W-1:0] wr_addr_s;
  logic [LEN_W-1:0]  wr_cnt_nxt_s;
  logic              rd_en_s;
  logic [LEN_W-1:0]  max_len_s;
  logic              any_len_s;
  logic [LEN_W-1:0]  nxt_addr_s;
  logic              last_s;
  logic [LEN_W-1:0]  fetch_s;
  logic [NUM_CH-1:0] fetch_act_s;
  logic              stall_s;
  logic [DATA_W-1:0] rdata_s [NUM_CH];

`ifdef DAC_PLAYBACK_LOOP_EN
  assign loop_s = loop_en;
`else
  logic unused_loop_en_s;
  assign unused_loop_en_s = loop_en;
  assign loop_s           = 1'b0;
`endif

  assign load_hs_s   = s_axis_tvalid & tready_q;
  assign trig_rise_s = trigger & ~trig_q;

  // Longest loaded buffer sets the playback length; any non-zero length arms the trigger.
  always_comb begin
    max_len_s = {LEN_W{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      if (len_q[i] > max_len_s) begin
        max_len_s = len_q[i];
      end else begin
        max_len_s = max_len_s;
      end
    end
    any_len_s = (max_len_s != {LEN_W{1'b0}});
  end

  // Next read address (prefetched one beat ahead), end-of-buffer and stall detection.
  always_comb begin
    nxt_addr_s = rd_addr_q + LEN_W'(1'b1);
    last_s     = (nxt_addr_s == max_len_s);
    if (!ovld_q) begin
      fetch_s = {LEN_W{1'b0}};
    end else if (last_s) begin
      fetch_s = {LEN_W{1'b0}};
    end else begin
      fetch_s = nxt_addr_s;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      fetch_act_s[i] = (fetch_s < len_q[i]);
    end
    stall_s = ovld_q & (|(tvalid_q & ~m_axis_tready));
  end

  // Controller next-state: load sequencing, trigger handling and lockstep playback.
  always_comb begin
    state_d      = state_q;
    tgt_d        = tgt_q;
    wr_cnt_d     = wr_cnt_q;
    len_d        = len_q;
    trig_d       = trigger;
    rd_addr_d    = rd_addr_q;
    ovld_d       = ovld_q;
    tvalid_d     = tvalid_q;
    done_d       = 1'b0;
    ovf_d        = ovf_q;
    und_d        = und_q;
    wr_en_s      = 1'b0;
    wr_ch_s      = tgt_q;
    wr_addr_s    = {ADDR_W{1'b0}};
    wr_cnt_nxt_s = wr_cnt_q;
    rd_en_s      = 1'b0;

    case (state_q)
      IDLE: begin
        if (load_hs_s) begin
          // First beat of a load: target comes from load_ch, word goes to address 0.
          wr_en_s = 1'b1;
          wr_ch_s = load_ch;
          tgt_d   = load_ch;
          if (s_axis_tlast) begin
            wr_cnt_d = {LEN_W{1'b0}};
            for (int i = 0; i < NUM_CH; i++) begin
              if (load_ch == CH_W'(i)) begin
                len_d[i] = LEN_W'(1'b1);
              end else begin
                len_d[i] = len_q[i];
              end
            end
          end else begin
            wr_cnt_d = LEN_W'(1'b1);
            state_d  = LOAD;
          end
        end else if (trig_rise_s && any_len_s) begin
          state_d   = PLAY;
          rd_addr_d = {LEN_W{1'b0}};
          ovld_d    = 1'b0;
          tvalid_d  = {NUM_CH{1'b0}};
          und_d     = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end

      LOAD: begin
        if (load_hs_s) begin
          if (wr_cnt_q < LEN_W'(DEPTH)) begin
            wr_en_s      = 1'b1;
            wr_addr_s    = wr_cnt_q[ADDR_W-1:0];
            wr_cnt_nxt_s = wr_cnt_q + LEN_W'(1'b1);
          end else begin
            // Buffer full: drop the beat, length stays saturated at DEPTH.
            ovf_d        = 1'b1;
            wr_cnt_nxt_s = wr_cnt_q;
          end
          if (s_axis_tlast) begin
            for (int i = 0; i < NUM_CH; i++) begin
              if (tgt_q == CH_W'(i)) begin
                len_d[i] = wr_cnt_nxt_s;
              end else begin
                len_d[i] = len_q[i];
              end
            end
            wr_cnt_d = {LEN_W{1'b0}};
            state_d  = IDLE;
          end else begin
            wr_cnt_d = wr_cnt_nxt_s;
          end
        end else begin
          state_d = LOAD;
        end
      end

      PLAY: begin
        if (abort) begin
          state_d  = IDLE;
          ovld_d   = 1'b0;
          tvalid_d = {NUM_CH{1'b0}};
        end else if (!ovld_q) begin
          // First fetch after the trigger; data appears on the next cycle.
          rd_en_s   = 1'b1;
          ovld_d    = 1'b1;
          rd_addr_d = fetch_s;
          tvalid_d  = fetch_act_s;
        end else if (stall_s) begin
          // A valid channel is not ready: hold every channel and flag it.
          und_d = 1'b1;
        end else if (last_s && !loop_s) begin
          state_d  = IDLE;
          done_d   = 1'b1;
          ovld_d   = 1'b0;
          tvalid_d = {NUM_CH{1'b0}};
        end else begin
          // Beat accepted everywhere: present the prefetched word (wraps to 0 when looping).
          rd_en_s   = 1'b1;
          rd_addr_d = fetch_s;
          tvalid_d  = fetch_act_s;
        end
      end

      default: begin
        state_d  = IDLE;
        ovld_d   = 1'b0;
        tvalid_d = {NUM_CH{1'b0}};
      end
    endcase

    busy_d   = (state_d != IDLE);
    tready_d = (state_d != PLAY);
  end

  // State and registered outputs; reset abandons any load or playback in flight.
  always_ff @(posedge pl_clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      tgt_q     <= {CH_W{1'b0}};
      wr_cnt_q  <= {LEN_W{1'b0}};
      for (int i = 0; i < NUM_CH; i++) begin
        len_q[i] <= {LEN_W{1'b0}};
      end
      trig_q    <= 1'b0;
      rd_addr_q <= {LEN_W{1'b0}};
      ovld_q    <= 1'b0;
      tvalid_q  <= {NUM_CH{1'b0}};
      tready_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      und_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tgt_q     <= tgt_d;
      wr_cnt_q  <= wr_cnt_d;
      len_q     <= len_d;
      trig_q    <= trig_d;
      rd_addr_q <= rd_addr_d;
      ovld_q    <= ovld_d;
      tvalid_q  <= tvalid_d;
      tready_q  <= tready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
      und_q     <= und_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic we_s;
    assign we_s = wr_en_s && (wr_ch_s == CH_W'(g));

    dac_channel_buffer #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_buf (
      .clk     (pl_clk),
      .wr_en   (we_s),
      .wr_addr (wr_addr_s),
      .wr_data (s_axis_tdata),
      .rd_en   (rd_en_s),
      .rd_addr (fetch_s[ADDR_W-1:0]),
      .rd_data (rdata_s[g])
    );

    // Inactive channels present zero data.
    assign m_axis_tdata[g*DATA_W +: DATA_W] = tvalid_q[g] ? rdata_s[g] : {DATA_W{1'b0}};
  end

  assign s_axis_tready = tready_q;
  assign m_axis_tvalid = tvalid_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign overflow      = ovf_q;
  assign underrun      = und_q;

endmodule

// File: tb/tb_dac_playback_ctrl.sv
// tb_dac_playback_ctrl: directed, table-driven bench for dac_playback_ctrl
// (4 channels, 32-bit words, 8-word buffers).
module tb_dac_playback_ctrl;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;

  logic                     pl_clk = 1'b0;
  logic                     rst;
  logic [DATA_W-1:0]        s_axis_tdata;
  logic                     s_axis_tvalid;
  logic                     s_axis_tlast;
  logic                     s_axis_tready;
  logic [1:0]               load_ch;
  logic                     trigger;
  logic                     loop_en;
  logic                     abort;
  logic [NUM_CH*DATA_W-1:0] m_axis_tdata;
  logic [NUM_CH-1:0]        m_axis_tvalid;
  logic [NUM_CH-1:0]        m_axis_tready;
  logic                     busy;
  logic                     done;
  logic                     overflow;
  logic                     underrun;

  dac_playback_ctrl #(
    .NUM_CH (NUM_CH),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .pl_clk        (pl_clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .load_ch       (load_ch),
    .trigger       (trigger),
    .loop_en       (loop_en),
    .abort         (abort),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .busy          (busy),
    .done          (done),
    .overflow      (overflow),
    .underrun      (underrun)
  );

  always #5 pl_clk = ~pl_clk;

  // One playback cycle: tready/abort applied, outputs expected in that cycle.
  typedef struct {
    logic [3:0] rdy;
    logic       abt;
    logic [3:0] vld;
    int         beat;
    logic       done;
    logic       busy;
    logic       und;
  } row_t;

  row_t rows[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  logic exp_ovf = 1'b0;

  function automatic logic [31:0] pat(input int ch, input int beat);
    return {8'hDA, 8'(ch), 16'(beat)};
  endfunction

  function automatic row_t mk(input logic [3:0] rdy, input logic abt, input logic [3:0] vld,
                              input int beat, input logic dn, input logic bsy, input logic und);
    row_t r;
    r.rdy = rdy; r.abt = abt; r.vld = vld; r.beat = beat;
    r.done = dn; r.busy = bsy; r.und = und;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge pl_clk);
    #1;
  endtask

  // Stream n beats into channel ch; later beats carry a different load_ch.
  task automatic load_beats(input int ch, input int n, input int trig_at);
    for (int b = 0; b < n; b++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = pat(ch, b);
      s_axis_tlast  = (b == n - 1);
      load_ch       = (b == 0) ? 2'(ch) : 2'(ch + 1);
      if (b >= trig_at) trigger = 1'b1;
      tick();
      if (b >= DEPTH) exp_ovf = 1'b1;
      chk("load_overflow", 64'(overflow), 64'(exp_ovf));
      chk("load_busy", 64'(busy), 64'(b < n - 1));
      chk("load_tready", 64'(s_axis_tready), 64'd1);
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic start_play;
    m_axis_tready = 4'hF;
    trigger = 1'b1;
    tick();
    chk("trig_busy", 64'(busy), 64'd1);
    chk("trig_tready", 64'(s_axis_tready), 64'd0);
    chk("trig_tvalid_early", 64'(m_axis_tvalid), 64'd0);
    chk("trig_underrun_clr", 64'(underrun), 64'd0);
    trigger = 1'b0;
    tick();
  endtask

  task automatic play_seg(input int lo, input int hi);
    for (int r = lo; r < hi; r++) begin
      m_axis_tready = rows[r].rdy;
      abort         = rows[r].abt;
      chk("tvalid", 64'(m_axis_tvalid), 64'(rows[r].vld));
      for (int c = 0; c < NUM_CH; c++) begin
        chk("tdata", 64'(m_axis_tdata[c*DATA_W +: DATA_W]),
            64'(rows[r].vld[c] ? pat(c, rows[r].beat) : 32'h0));
      end
      chk("done", 64'(done), 64'(rows[r].done));
      chk("busy", 64'(busy), 64'(rows[r].busy));
      chk("underrun", 64'(underrun), 64'(rows[r].und));
      tick();
    end
    abort = 1'b0;
  endtask

  int sa, sb, sc, sd, se, sf, sg, send;

  initial begin
    // ---------------- expected playback tables ----------------
    sa = rows.size();   // ch3 alone, 4 beats
    for (int b = 0; b < 4; b++) rows.push_back(mk(4'hF, 1'b0, 4'b1000, b, 1'b0, 1'b1, 1'b0));
    rows.push_back(mk(4'hF, 1'b0, 4'b0000, 0, 1'b1, 1'b0, 1'b0));
    rows.push_back(mk(4'hF, 1'b0, 4'b0000, 0, 1'b0, 1'b0, 1'b0));
    sb = rows.size();   // ch0 len2, ch1 len5, ch3 len4 kept
    rows.push_back(mk(4'hF, 1'b0, 4'b1011, 0, 1'b0, 1'b1, 1'b0));
    rows.push_back(mk(4'hF, 1'b0, 4'b1011, 1, 1'b0, 1'b1, 1'b0));
    rows.push_back(mk(4'hF, 1'b0, 4'b1010, 2, 1'b0, 1'b1, 1'b0));
    rows.push_back(mk(4'hF, 1'b0, 4'b1010, 3, 1'b0, 1'b1, 1'b0));
    rows.push_back(mk(4'hF, 1'b0, 4'b0010, 4, 1'b0, 1'b1, 1'b0));
    rows.push_back(mk(4'hF, 1'b0, 4'b0000, 0, 1'b1, 1'b0, 1'b0));
    sc = rows.size();   // ch1 not ready for 3 cycles on beat 1
    rows.push_back(mk(4'hF,    1'b0, 4'b1011, 0, 1'b0, 1'b1, 1'b0));
    rows.push_back(mk(4'b1101, 1'b0, 4'b1011, 1, 1'b0, 1'b1, 1'b0));
    rows.push_back(mk(4'b1101, 1'b0, 4'b1011, 1, 1'b0, 1'b1, 1'b1));
    rows.push_back(mk(4'b1101, 1'b0, 4'b1011, 1, 1'b0, 1'b1, 1'b1));
    rows.push_back(mk(4'hF,    1'b0, 4'b1011, 1, 1'b0, 1'b1, 1'b1));
    rows.push_back(mk(4'hF,    1'b0, 4'b1010, 2, 1'b0, 1'b1, 1'b1));
    rows.push_back(mk(4'hF,    1'b0, 4'b1010, 3, 1'b0, 1'b1, 1'b1));
    rows.push_back(mk(4'b0010, 1'b0, 4'b0010, 4, 1'b0, 1'b1, 1'b1));
    rows.push_back(mk(4'hF,    1'b0, 4'b0000, 0, 1'b1, 1'b0, 1'b1));
    sd = rows.size();   // two beats, then reset
    rows.push_back(mk(4'hF, 1'b0, 4'b1011, 0, 1'b0, 1'b1, 1'b0));
    rows.push_back(mk(4'hF, 1'b0, 4'b1011, 1, 1'b0, 1'b1, 1'b0));
    se = rows.size();   // ch2 len3 with loop_en=1
`ifdef DAC_PLAYBACK_LOOP_EN
    for (int k = 0; k < 6; k++) rows.push_back(mk(4'hF, 1'b0, 4'b0100, k % 3, 1'b0, 1'b1, 1'b0));
    rows.push_back(mk(4'hF, 1'b1, 4'b0100, 0, 1'b0, 1'b1, 1'b0));
    rows.push_back(mk(4'hF, 1'b0, 4'b0000, 0, 1'b0, 1'b0, 1'b0));
    rows.push_back(mk(4'hF, 1'b0, 4'b0000, 0, 1'b0, 1'b0, 1'b0));
`else
    for (int k = 0; k < 3; k++) rows.push_back(mk(4'hF, 1'b0, 4'b0100, k, 1'b0, 1'b1, 1'b0));
    rows.push_back(mk(4'hF, 1'b0, 4'b0000, 0, 1'b1, 1'b0, 1'b0));
    rows.push_back(mk(4'hF, 1'b0, 4'b0000, 0, 1'b0, 1'b0, 1'b0));
`endif
    sf = rows.size();   // abort on beat 1
    rows.push_back(mk(4'hF, 1'b0, 4'b0100, 0, 1'b0, 1'b1, 1'b0));
    rows.push_back(mk(4'hF, 1'b1, 4'b0100, 1, 1'b0, 1'b1, 1'b0));
    rows.push_back(mk(4'hF, 1'b0, 4'b0000, 0, 1'b0, 1'b0, 1'b0));
    rows.push_back(mk(4'hF, 1'b0, 4'b0000, 0, 1'b0, 1'b0, 1'b0));
    sg = rows.size();   // ch0 len8 (overflowed), ch1 len1, ch2 len3
    rows.push_back(mk(4'hF, 1'b0, 4'b0111, 0, 1'b0, 1'b1, 1'b0));
    rows.push_back(mk(4'hF, 1'b0, 4'b0101, 1, 1'b0, 1'b1, 1'b0));
    rows.push_back(mk(4'hF, 1'b0, 4'b0101, 2, 1'b0, 1'b1, 1'b0));
    for (int b = 3; b < 8; b++) rows.push_back(mk(4'hF, 1'b0, 4'b0001, b, 1'b0, 1'b1, 1'b0));
    rows.push_back(mk(4'hF, 1'b0, 4'b0000, 0, 1'b1, 1'b0, 1'b0));
    send = rows.size();

    // ---------------- reset ----------------
    rst = 1'b1; s_axis_tdata = 32'h0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    load_ch = 2'd0; trigger = 1'b0; loop_en = 1'b0; abort = 1'b0; m_axis_tready = 4'hF;
    tick(); tick();
    chk("rst_tready", 64'(s_axis_tready), 64'd0);
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_tdata", 64'(m_axis_tdata[63:0]), 64'd0);
    chk("rst_status", 64'({busy, done, overflow, underrun}), 64'd0);
    rst = 1'b0;
    tick();
    chk("idle_tready", 64'(s_axis_tready), 64'd1);

    // Trigger with every length zero is ignored.
    trigger = 1'b1; tick();
    chk("empty_trig_busy", 64'(busy), 64'd0);
    trigger = 1'b0; tick();

    // ch3, 4 beats.
    load_beats(3, 4, 99);
    start_play(); play_seg(sa, sb);

    // ch0 len2, ch1 len5.
    load_beats(0, 2, 99);
    load_beats(1, 5, 99);
    start_play(); play_seg(sb, sc);

    // Back-pressure on ch1.
    start_play(); play_seg(sc, sd);

    // Reset during playback, then a trigger with no reload.
    start_play(); play_seg(sd, se);
    rst = 1'b1; #1;
    chk("mid_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("mid_rst_tdata", 64'(m_axis_tdata[127:64]), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_tready", 64'(s_axis_tready), 64'd0);
    tick(); rst = 1'b0; tick();
    chk("post_rst_tready", 64'(s_axis_tready), 64'd1);
    trigger = 1'b1; tick();
    chk("post_rst_trig_busy", 64'(busy), 64'd0);
    chk("post_rst_trig_tvalid", 64'(m_axis_tvalid), 64'd0);
    trigger = 1'b0; tick();
    chk("post_rst_idle_tvalid", 64'(m_axis_tvalid), 64'd0);

    // ch2 len3 with loop_en set.
    load_beats(2, 3, 99);
    loop_en = 1'b1;
    start_play(); play_seg(se, sf);
    loop_en = 1'b0;

    // Abort mid-playback.
    start_play(); play_seg(sf, sg);

    // Single-beat load, overflowing load with a trigger pulse during LOAD.
    load_beats(1, 1, 99);
    load_beats(0, 10, 3);
    trigger = 1'b0; tick();
    chk("load_trig_ignored", 64'(busy), 64'd0);
    start_play(); play_seg(sg, send);
    chk("overflow_sticky", 64'(overflow), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
